// File: rtl/proc_pkg.sv
// Shared definitions for the processor control path: sequencer states,
// opcode values, instruction field positions and opcode classification.
package proc_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // Instruction classes that share one step sequence
    typedef enum logic [2:0] {
        CL_LOAD,
        CL_COPY,
        CL_BIN,
        CL_UN,
        CL_SHIFT,
        CL_ILL
    } op_class_t;

    localparam int unsigned IR_W    = 10;
    localparam int unsigned OPC_MSB = 9;
    localparam int unsigned OPC_LSB = 6;
    localparam int unsigned RX_MSB  = 5;
    localparam int unsigned RX_LSB  = 4;
    localparam int unsigned RY_MSB  = 3;
    localparam int unsigned RY_LSB  = 2;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_COPY = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_NEG  = 4'b0100;
    localparam logic [3:0] OP_INV  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_LSL  = 4'b1001;
    localparam logic [3:0] OP_LSR  = 4'b1010;
    localparam logic [3:0] OP_ASR  = 4'b1011;

    function automatic op_class_t classify(input logic [3:0] op);
        op_class_t cls;
        case (op)
            OP_LOAD:                                cls = CL_LOAD;
            OP_COPY:                                cls = CL_COPY;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:  cls = CL_BIN;
            OP_NEG, OP_INV:                         cls = CL_UN;
            OP_LSL, OP_LSR, OP_ASR:                 cls = CL_SHIFT;
            default:                                cls = CL_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/dec2to4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module dec2to4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    // Raise exactly the selected line while enabled
    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer for a four-register bus datapath. Captures an
// instruction on Exec in T0, then steps T1..T3 producing Moore control
// strobes decoded from state and IR. All state changes on the falling edge.
module control_sequencer
    import proc_pkg::*;
(
    input  logic       CLKb,
    input  logic       RSTb,
    input  logic       Exec,
    input  logic [9:0] INSTR,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic [3:0] FN,
    output logic [3:0] Rin,
    output logic [3:0] Rout,
    output logic       Extrn,
    output logic       Done,
    output logic       Busy,
    output logic       Ill
);

    state_t            state;
    state_t            next_state;
    logic [IR_W-1:0]   ir;

    logic [3:0]        opcode;
    logic [1:0]        rx;
    logic [1:0]        ry;
    op_class_t         cls;

    logic              rin_en;
    logic [1:0]        rin_sel;
    logic              rout_en;
    logic [1:0]        rout_sel;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign rx     = ir[RX_MSB:RX_LSB];
    assign ry     = ir[RY_MSB:RY_LSB];
    assign cls    = classify(opcode);

    // State and instruction register; IR loads only when a start is accepted
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == T0 && Exec) begin
                ir <= INSTR;
            end
        end
    end

    // Next-state and per-step control decode
    always_comb begin
        next_state = state;
        Ain        = 1'b0;
        Gin        = 1'b0;
        Gout       = 1'b0;
        Extrn      = 1'b0;
        Done       = 1'b0;
        Ill        = 1'b0;
        rin_en     = 1'b0;
        rin_sel    = '0;
        rout_en    = 1'b0;
        rout_sel   = '0;

        case (state)
            T0: begin
                if (Exec) begin
                    next_state = T1;
                end
            end
            T1: begin
                case (cls)
                    CL_LOAD: begin
                        Extrn      = 1'b1;
                        rin_en     = 1'b1;
                        rin_sel    = rx;
                        Done       = 1'b1;
                        next_state = T0;
                    end
                    CL_COPY: begin
                        rout_en    = 1'b1;
                        rout_sel   = ry;
                        rin_en     = 1'b1;
                        rin_sel    = rx;
                        Done       = 1'b1;
                        next_state = T0;
                    end
                    CL_BIN: begin
                        rout_en    = 1'b1;
                        rout_sel   = rx;
                        Ain        = 1'b1;
                        next_state = T2;
                    end
                    CL_UN: begin
                        rout_en    = 1'b1;
                        rout_sel   = ry;
                        Ain        = 1'b1;
                        next_state = T2;
                    end
                    CL_SHIFT: begin
                        rout_en    = 1'b1;
                        rout_sel   = rx;
                        Gin        = 1'b1;
                        next_state = T2;
                    end
                    default: begin
                        Done       = 1'b1;
                        Ill        = 1'b1;
                        next_state = T0;
                    end
                endcase
            end
            T2: begin
                case (cls)
                    CL_BIN: begin
                        rout_en    = 1'b1;
                        rout_sel   = ry;
                        Gin        = 1'b1;
                        next_state = T3;
                    end
                    CL_UN: begin
                        Gin        = 1'b1;
                        next_state = T3;
                    end
                    CL_SHIFT: begin
                        Gout       = 1'b1;
                        rin_en     = 1'b1;
                        rin_sel    = rx;
                        Done       = 1'b1;
                        next_state = T0;
                    end
                    default: begin
                        next_state = T0;
                    end
                endcase
            end
            T3: begin
                Gout       = 1'b1;
                rin_en     = 1'b1;
                rin_sel    = rx;
                Done       = 1'b1;
                next_state = T0;
            end
            default: begin
                next_state = T0;
            end
        endcase
    end

    // Function code is meaningful only while a legal instruction is running
    always_comb begin
        FN   = '0;
        Busy = (state != T0);
        if (state != T0 && cls != CL_ILL) begin
            FN = opcode;
        end
    end

    dec2to4 u_rin_dec (
        .sel (rin_sel),
        .en  (rin_en),
        .y   (Rin)
    );

    dec2to4 u_rout_dec (
        .sel (rout_sel),
        .en  (rout_en),
        .y   (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus
// randomized instructions checked against a step-list reference model.
module tb_control_sequencer;

    logic       CLKb;
    logic       RSTb;
    logic       Exec;
    logic [9:0] INSTR;
    logic       Ain, Gin, Gout, Extrn, Done, Busy, Ill;
    logic [3:0] FN, Rin, Rout;

    typedef struct packed {
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] fn;
        logic [3:0] rin;
        logic [3:0] rout;
        logic       extrn;
        logic       done;
        logic       busy;
        logic       ill;
    } outs_t;

    outs_t obs;
    outs_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    assign obs = {Ain, Gin, Gout, FN, Rin, Rout, Extrn, Done, Busy, Ill};

    control_sequencer dut (
        .CLKb  (CLKb),
        .RSTb  (RSTb),
        .Exec  (Exec),
        .INSTR (INSTR),
        .Ain   (Ain),
        .Gin   (Gin),
        .Gout  (Gout),
        .FN    (FN),
        .Rin   (Rin),
        .Rout  (Rout),
        .Extrn (Extrn),
        .Done  (Done),
        .Busy  (Busy),
        .Ill   (Ill)
    );

    initial begin
        CLKb = 1'b1;
        forever #5 CLKb = ~CLKb;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic outs_t step(input logic ain, input logic gin, input logic gout,
                                   input logic [3:0] fn, input logic [3:0] rin,
                                   input logic [3:0] rout, input logic extrn,
                                   input logic done, input logic ill);
        outs_t s;
        s.ain = ain; s.gin = gin; s.gout = gout; s.fn = fn; s.rin = rin;
        s.rout = rout; s.extrn = extrn; s.done = done; s.busy = 1'b1; s.ill = ill;
        return s;
    endfunction

    // Reference: list of expected output vectors for each busy cycle
    function automatic void build_expected(input logic [9:0] instr);
        logic [3:0] op;
        logic [3:0] xh;
        logic [3:0] yh;
        op = instr[9:6];
        xh = 4'b0001 << instr[5:4];
        yh = 4'b0001 << instr[3:2];
        exp_q.delete();
        if (op == 4'd0) begin
            exp_q.push_back(step(0, 0, 0, op, xh, 4'b0, 1, 1, 0));
        end else if (op == 4'd1) begin
            exp_q.push_back(step(0, 0, 0, op, xh, yh, 0, 1, 0));
        end else if (op == 4'd2 || op == 4'd3 || op == 4'd6 || op == 4'd7 || op == 4'd8) begin
            exp_q.push_back(step(1, 0, 0, op, 4'b0, xh, 0, 0, 0));
            exp_q.push_back(step(0, 1, 0, op, 4'b0, yh, 0, 0, 0));
            exp_q.push_back(step(0, 0, 1, op, xh, 4'b0, 0, 1, 0));
        end else if (op == 4'd4 || op == 4'd5) begin
            exp_q.push_back(step(1, 0, 0, op, 4'b0, yh, 0, 0, 0));
            exp_q.push_back(step(0, 1, 0, op, 4'b0, 4'b0, 0, 0, 0));
            exp_q.push_back(step(0, 0, 1, op, xh, 4'b0, 0, 1, 0));
        end else if (op >= 4'd9 && op <= 4'd11) begin
            exp_q.push_back(step(0, 1, 0, op, 4'b0, xh, 0, 0, 0));
            exp_q.push_back(step(0, 0, 1, op, xh, 4'b0, 0, 1, 0));
        end else begin
            exp_q.push_back(step(0, 0, 0, 4'b0, 4'b0, 4'b0, 0, 1, 1));
        end
    endfunction

    // Called just after the falling edge that entered T1; Exec/INSTR are
    // scrambled while busy to show they are ignored
    task automatic run_steps(input string name, input logic [9:0] instr);
        int nsteps;
        build_expected(instr);
        nsteps = exp_q.size();
        for (int k = 0; k < nsteps; k++) begin
            #1;
            Exec  = 1'($urandom);
            INSTR = 10'($urandom);
            @(posedge CLKb);
            n_tests++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL %s instr=%b step T%0d: got %h required %h", name, instr, k + 1, obs, exp_q[k]);
            end
            n_tests++;
            if (($countones(Rout) + Gout + Extrn) > 1) begin
                n_fail++;
                $display("FAIL %s bus_drivers step T%0d: got Rout=%b Gout=%b Extrn=%b required at most one driver",
                         name, k + 1, Rout, Gout, Extrn);
            end
        end
        Exec = 1'b0;
    endtask

    task automatic run_instr(input string name, input logic [9:0] instr);
        @(posedge CLKb);
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL %s idle_before: got %h required %h", name, obs, 19'h0);
        end
        Exec  = 1'b1;
        INSTR = instr;
        @(negedge CLKb);
        run_steps(name, instr);
    endtask

    task automatic test_reset();
        RSTb  = 1'b0;
        Exec  = 1'b1;
        INSTR = 10'b0010_01_10_00;
        repeat (3) begin
            @(posedge CLKb);
            n_tests++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: got %h required %h", obs, 19'h0);
            end
        end
        RSTb = 1'b1;
        @(negedge CLKb);
        run_steps("reset_then_add", 10'b0010_01_10_00);
    endtask

    task automatic test_idle_hold();
        Exec = 1'b0;
        for (int i = 0; i < 4; i++) begin
            INSTR = 10'($urandom);
            @(posedge CLKb);
            n_tests++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL idle_hold cycle %0d: got %h required %h", i, obs, 19'h0);
            end
        end
    endtask

    task automatic test_directed();
        run_instr("load", 10'b0000_10_00_00);
        run_instr("sub", 10'b0011_00_11_00);
        run_instr("asr", 10'b1011_01_00_00);
        run_instr("illegal", 10'b1110_00_00_00);
        run_instr("copy", 10'b0001_11_01_00);
        run_instr("neg", 10'b0100_10_01_00);
        run_instr("and_same_reg", 10'b0110_10_10_00);
        run_instr("lsl_same_reg", 10'b1001_11_11_00);
        run_instr("illegal_max", 10'b1111_11_11_11);
    endtask

    task automatic test_mid_reset();
        @(posedge CLKb);
        Exec  = 1'b1;
        INSTR = 10'b1000_11_01_00;
        @(negedge CLKb);
        #1 Exec = 1'b0;
        @(posedge CLKb);
        n_tests++;
        if (obs !== step(1, 0, 0, 4'b1000, 4'b0, 4'b1000, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL mid_reset_t1: got %h required %h", obs, step(1, 0, 0, 4'b1000, 4'b0, 4'b1000, 0, 0, 0));
        end
        @(negedge CLKb);
        #2;
        n_tests++;
        if (obs !== step(0, 1, 0, 4'b1000, 4'b0, 4'b0010, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL mid_reset_t2: got %h required %h", obs, step(0, 1, 0, 4'b1000, 4'b0, 4'b0010, 0, 0, 0));
        end
        RSTb = 1'b0;
        #1;
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_immediate: got %h required %h", obs, 19'h0);
        end
        repeat (2) begin
            @(posedge CLKb);
            n_tests++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL mid_reset_no_done: got %h required %h", obs, 19'h0);
            end
        end
        RSTb = 1'b1;
        run_instr("after_reset_or", 10'b0111_01_11_00);
    endtask

    task automatic test_back_to_back();
        logic [9:0] instr;
        for (int i = 0; i < 40; i++) begin
            instr = 10'($urandom_range(0, 1023));
            run_instr("random", instr);
        end
    endtask

    initial begin
        RSTb  = 1'b0;
        Exec  = 1'b0;
        INSTR = '0;
        #2;
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: got %h required %h", obs, 19'h0);
        end
        test_reset();
        test_idle_hold();
        test_directed();
        test_mid_reset();
        test_back_to_back();
        @(posedge CLKb);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
